adsr_mngt: RTL and testbench

ADSR_MNGT -- requirements
Module: adsr_mngt

---
 rtl/adsr_mngt_pkg.sv | 27 ++
 rtl/adsr_next.sv | 80 ++++++++
 rtl/adsr_mngt.sv | 64 ++++++
 tb/tb_adsr_mngt.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/adsr_mngt_pkg.sv
// adsr_mngt_pkg: shared envelope state encodings, widths and step helpers
package adsr_mngt_pkg;

    typedef enum logic [2:0] {
        BLANK   = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int VOL_W         = 18;
    localparam int RATE_W        = 7;
    localparam logic [VOL_W-1:0] VOL_MAX = 18'h3FFFF;
    localparam int RATE_SHIFT    = 4;
    localparam int SUSTAIN_SHIFT = 11;

    // Per-sample step: rate scaled by 16, zero-extended to the volume width.
    function automatic logic [VOL_W-1:0] rate_step(input logic [RATE_W-1:0] r);
        return {{(VOL_W-RATE_W-RATE_SHIFT){1'b0}}, r, {RATE_SHIFT{1'b0}}};
    endfunction

    function automatic logic [VOL_W-1:0] sustain_level(input logic [RATE_W-1:0] s);
        return {s, {SUSTAIN_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/adsr_next.sv
// adsr_next: combinational next envelope state/volume for one voice sample
// Inputs : i_state, i_volume, i_note_pressed, i_note_released, sustain_value,
//          attack_rate, decay_rate, release_rate
// Outputs: o_state, o_volume, o_note_pressed, o_note_released
module adsr_next
    import adsr_mngt_pkg::*;
(
    input  logic [2:0]        i_state,
    input  logic [VOL_W-1:0]  i_volume,
    input  logic              i_note_pressed,
    input  logic              i_note_released,
    input  logic [RATE_W-1:0] sustain_value,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [RATE_W-1:0] release_rate,
    output logic [2:0]        o_state,
    output logic [VOL_W-1:0]  o_volume,
    output logic              o_note_pressed,
    output logic              o_note_released
);

    logic [VOL_W-1:0] a_step, d_step, r_step, level;
    logic [VOL_W:0]   a_sum, d_floor;
    logic             a_top, d_done, r_done;

    // Sums are one bit wider so the saturation tests never see a wrapped value.
    always_comb begin
        a_step  = rate_step(attack_rate);
        d_step  = rate_step(decay_rate);
        r_step  = rate_step(release_rate);
        level   = sustain_level(sustain_value);
        a_sum   = {1'b0, i_volume} + {1'b0, a_step};
        d_floor = {1'b0, level} + {1'b0, d_step};
        a_top   = (attack_rate == '0) || (a_sum >= {1'b0, VOL_MAX});
        d_done  = (decay_rate == '0) || ({1'b0, i_volume} <= d_floor);
        r_done  = (release_rate == '0) || (i_volume <= r_step);
    end

    // Every legal path consumes both flags, so they leave as zero; a corrupt
    // state is squashed to silence ahead of any pending event.
    always_comb begin
        o_state         = BLANK;
        o_volume        = '0;
        o_note_pressed  = 1'b0;
        o_note_released = 1'b0;
        if (i_state > RELEASE) begin
            o_state = BLANK;
        end else if (i_note_pressed) begin
            o_state  = ATTACK;
            o_volume = i_volume;
        end else if (i_note_released && i_state inside {ATTACK, DECAY, SUSTAIN}) begin
            o_state  = RELEASE;
            o_volume = i_volume;
        end else begin
            case (i_state)
                ATTACK: begin
                    o_state  = a_top ? DECAY : ATTACK;
                    o_volume = a_top ? VOL_MAX : a_sum[VOL_W-1:0];
                end
                DECAY: begin
                    o_state  = d_done ? SUSTAIN : DECAY;
                    o_volume = d_done ? level : i_volume - d_step;
                end
                SUSTAIN: begin
                    o_state  = SUSTAIN;
                    o_volume = level;
                end
                RELEASE: begin
                    o_state  = r_done ? BLANK : RELEASE;
                    o_volume = r_done ? '0 : i_volume - r_step;
                end
                default: begin
                    o_state  = BLANK;
                    o_volume = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adsr_mngt.sv
// adsr_mngt: one-cycle registered ADSR envelope update for a voice record
// Inputs : clk, rst (async, active low), i_valid, i_state, i_volume,
//          i_note_pressed, i_note_released, sustain_value, attack/decay/release_rate
// Outputs: o_valid, o_state, o_volume, o_note_pressed, o_note_released
module adsr_mngt
    import adsr_mngt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [2:0]        i_state,
    input  logic [VOL_W-1:0]  i_volume,
    input  logic              i_note_pressed,
    input  logic              i_note_released,
    input  logic [RATE_W-1:0] sustain_value,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [RATE_W-1:0] release_rate,
    output logic              o_valid,
    output logic [2:0]        o_state,
    output logic [VOL_W-1:0]  o_volume,
    output logic              o_note_pressed,
    output logic              o_note_released
);

    logic [2:0]       n_state;
    logic [VOL_W-1:0] n_volume;
    logic             n_pressed, n_released;

    adsr_next u_next (
        .i_state         (i_state),
        .i_volume        (i_volume),
        .i_note_pressed  (i_note_pressed),
        .i_note_released (i_note_released),
        .sustain_value   (sustain_value),
        .attack_rate     (attack_rate),
        .decay_rate      (decay_rate),
        .release_rate    (release_rate),
        .o_state         (n_state),
        .o_volume        (n_volume),
        .o_note_pressed  (n_pressed),
        .o_note_released (n_released)
    );

    // The record registers only load on a valid sample; otherwise they hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid         <= 1'b0;
            o_state         <= BLANK;
            o_volume        <= '0;
            o_note_pressed  <= 1'b0;
            o_note_released <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_state         <= n_state;
                o_volume        <= n_volume;
                o_note_pressed  <= n_pressed;
                o_note_released <= n_released;
            end
        end
    end

endmodule

// File: tb/tb_adsr_mngt.sv
// tb_adsr_mngt: randomized and directed checks of adsr_mngt against an arithmetic model
module tb_adsr_mngt;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [2:0]  i_state = '0;
    logic [17:0] i_volume = '0;
    logic        i_note_pressed = 1'b0;
    logic        i_note_released = 1'b0;
    logic [6:0]  sustain_value = '0;
    logic [6:0]  attack_rate = '0;
    logic [6:0]  decay_rate = '0;
    logic [6:0]  release_rate = '0;
    logic        o_valid;
    logic [2:0]  o_state;
    logic [17:0] o_volume;
    logic        o_note_pressed;
    logic        o_note_released;

    int checks = 0;
    int errors = 0;
    int e_st = 0;
    int e_vol = 0;

    always #5 clk = ~clk;

    adsr_mngt dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .i_state         (i_state),
        .i_volume        (i_volume),
        .i_note_pressed  (i_note_pressed),
        .i_note_released (i_note_released),
        .sustain_value   (sustain_value),
        .attack_rate     (attack_rate),
        .decay_rate      (decay_rate),
        .release_rate    (release_rate),
        .o_valid         (o_valid),
        .o_state         (o_state),
        .o_volume        (o_volume),
        .o_note_pressed  (o_note_pressed),
        .o_note_released (o_note_released)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Envelope rules in plain integer arithmetic: steps are rate*16, level is sustain*2048.
    function automatic void model(input int st, input int vol, input int p, input int r,
                                  input int sus, input int ar, input int dr, input int rr,
                                  output int nst, output int nvol);
        int lvl = sus * 2048;
        nst = st;
        nvol = vol;
        if (st > 4) begin
            nst = 0;
            nvol = 0;
        end else if (p != 0) begin
            nst = 1;
        end else if (r != 0 && st >= 1 && st <= 3) begin
            nst = 4;
        end else if (st == 0) begin
            nvol = 0;
        end else if (st == 1) begin
            if (ar == 0 || vol + ar * 16 >= 262143) begin
                nst = 2;
                nvol = 262143;
            end else nvol = vol + ar * 16;
        end else if (st == 2) begin
            if (dr == 0 || vol <= lvl + dr * 16) begin
                nst = 3;
                nvol = lvl;
            end else nvol = vol - dr * 16;
        end else if (st == 3) begin
            nvol = lvl;
        end else begin
            if (rr == 0 || vol <= rr * 16) begin
                nst = 0;
                nvol = 0;
            end else nvol = vol - rr * 16;
        end
    endfunction

    task automatic apply(input int v, input int st, input int vol, input int p, input int r,
                         input int sus, input int ar, input int dr, input int rr);
        i_valid = v[0];
        i_state = st[2:0];
        i_volume = vol[17:0];
        i_note_pressed = p[0];
        i_note_released = r[0];
        sustain_value = sus[6:0];
        attack_rate = ar[6:0];
        decay_rate = dr[6:0];
        release_rate = rr[6:0];
        if (v != 0) model(st, vol, p, r, sus, ar, dr, rr, e_st, e_vol);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int v);
        check({tag, ".valid"}, int'(o_valid), v);
        check({tag, ".state"}, int'(o_state), e_st);
        check({tag, ".vol"}, int'(o_volume), e_vol);
        check({tag, ".press"}, int'(o_note_pressed), 0);
        check({tag, ".rel"}, int'(o_note_released), 0);
    endtask

    task automatic vec(input string tag, input int st, input int vol, input int p, input int r,
                       input int sus, input int ar, input int dr, input int rr,
                       input int xst, input int xvol);
        apply(1, st, vol, p, r, sus, ar, dr, rr);
        check({tag, ".state"}, int'(o_state), xst);
        check({tag, ".vol"}, int'(o_volume), xvol);
        check({tag, ".flags"}, int'({o_note_pressed, o_note_released}), 0);
        check({tag, ".valid"}, int'(o_valid), 1);
    endtask

    task automatic hold3(input string tag);
        for (int k = 0; k < 3; k++) begin
            apply(0, $urandom_range(0, 4), $urandom, 1, 1, $urandom, $urandom, $urandom, $urandom);
            check_all(tag, 0);
        end
    endtask

    task automatic random_run(input int n);
        int st, vol, p, r, sel;
        for (int k = 0; k < n; k++) begin
            sel = $urandom_range(0, 3);
            if (o_valid && $urandom_range(0, 1) == 1) begin
                st = e_st;
                vol = e_vol;
            end else begin
                st = $urandom_range(0, 7);
                vol = sel == 0 ? 0 : sel == 1 ? 262143 - $urandom_range(0, 64) : int'($urandom_range(0, 262143));
            end
            p = ($urandom_range(0, 7) == 0 && st <= 4) ? 1 : 0;
            r = $urandom_range(0, 3) == 0 ? 1 : 0;
            apply($urandom_range(0, 4) != 0 ? 1 : 0, st, vol, p, r, $urandom_range(0, 127),
                  $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 127),
                  $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 127),
                  $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 127));
            check_all("rand", int'(i_valid));
        end
    endtask

    initial begin
        i_valid = 1'b1;
        i_volume = 18'h1234;
        #12;
        check_all("reset", 0);
        i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vec("press", 0, 0, 1, 1, 0, 'h20, 0, 0, 1, 0);
        vec("att1", 1, 0, 0, 0, 0, 'h20, 0, 0, 1, 'h200);
        hold3("hold_att");
        vec("att_top", 1, 'h3FF00, 0, 0, 0, 'h20, 0, 0, 2, 'h3FFFF);
        vec("att_zero", 1, 'h100, 0, 0, 0, 0, 0, 0, 2, 'h3FFFF);
        vec("dec_floor", 2, 'h20100, 0, 0, 'h40, 0, 'h20, 0, 3, 'h20000);
        vec("dec_step", 2, 'h30000, 0, 0, 'h40, 0, 'h20, 0, 2, 'h2FE00);
        vec("sus_track", 3, 'h20000, 0, 0, 'h10, 0, 0, 0, 3, 'h08000);
        vec("rel_evt", 3, 'h20000, 0, 1, 'h40, 0, 0, 8, 4, 'h20000);
        vec("rel_end", 4, 'h50, 0, 0, 0, 0, 0, 8, 0, 0);
        vec("rel_step", 4, 'h1000, 0, 1, 0, 0, 0, 8, 4, 'hF80);
        vec("illegal", 6, 'h12345, 0, 1, 0, 0, 0, 0, 0, 0);
        e_st = 0;
        e_vol = 0;
        hold3("hold_ill");
        random_run(400);
        i_valid = 1'b1;
        i_state = 3'd1;
        i_volume = 18'h100;
        #3;
        rst = 1'b0;
        #1;
        e_st = 0;
        e_vol = 0;
        check_all("mid_reset", 0);
        @(posedge clk);
        #1;
        check_all("reset_hold", 0);
        rst = 1'b1;
        vec("first_after", 1, 'h100, 0, 0, 0, 'h10, 0, 0, 1, 'h200);
        random_run(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
